// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack and its execute stage:
// opcode encodings, FSM state encoding and opcode classification helpers.
package stack_pkg;

  localparam int STACK_WIDTH = 32;
  localparam int STACK_DEPTH = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_NEG = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_POPB,
    ST_POPA,
    ST_EXEC,
    ST_PUSH,
    ST_DONE
  } exec_state_t;

  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_NOT) || (op == OP_NEG);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_NEG;
  endfunction

endpackage

// File: rtl/stack_alu_core.sv
// Combinational ALU for the stack execute stage: (op_a, op_b, opcode) -> (value, carry).
// A is the deeper operand, B the top of stack or immediate.
module stack_alu_core
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic [4:0]     shamt;
  logic           shift_oob;
  logic           lt;

  assign sum_ext   = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext  = {1'b0, op_a} - {1'b0, op_b};
  assign shamt     = op_b[4:0];
  // Only reachable for data widths narrower than 32 bits.
  assign shift_oob = int'(shamt) >= WIDTH;
  assign lt        = $signed(op_a) < $signed(op_b);

  always_comb begin
    value = '0;
    carry = 1'b0;
    case (opcode)
      OP_ADD: begin
        value = sum_ext[WIDTH-1:0];
        carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        value = diff_ext[WIDTH-1:0];
        carry = diff_ext[WIDTH];
      end
      OP_AND: value = op_a & op_b;
      OP_OR:  value = op_a | op_b;
      OP_XOR: value = op_a ^ op_b;
      OP_SHL: value = shift_oob ? '0 : (op_a << shamt);
      OP_SHR: value = shift_oob ? '0 : (op_a >> shamt);
      OP_SLT: value = {{(WIDTH-1){1'b0}}, lt};
      OP_NOT: value = ~op_a;
      OP_NEG: value = '0 - op_a;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/stack_alu_exec.sv
// Execute stage: pops operands from the stack, runs the ALU and pushes the result,
// sequenced by a small FSM with one-cycle pop/push strobes.
module stack_alu_exec
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] tos,
  input  logic [CNT_W-1:0] stack_count,
  output logic             pop_req,
  output logic             push_req,
  output logic [WIDTH-1:0] push_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             err
);

  exec_state_t      state_reg, state_next;
  logic [3:0]       opcode_reg;
  logic             use_imm_reg;
  logic [WIDTH-1:0] imm_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [WIDTH-1:0] alu_value;
  logic             alu_carry;
  logic             unary;
  logic             imm_binary;
  logic [CNT_W-1:0] needed;
  logic             chk_fail;

  assign unary      = is_unary(opcode_reg);
  assign imm_binary = use_imm_reg && !unary;
  assign needed     = (unary || use_imm_reg) ? CNT_W'(1) : CNT_W'(2);
  assign chk_fail   = !is_legal(opcode_reg) || (stack_count < needed);

  stack_alu_core #(.WIDTH(WIDTH)) u_core (
    .op_a   (op_a_reg),
    .op_b   (op_b_reg),
    .opcode (opcode_reg),
    .value  (alu_value),
    .carry  (alu_carry)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CHECK;
      ST_CHECK: begin
        if (chk_fail)                    state_next = ST_DONE;
        else if (!unary && !use_imm_reg) state_next = ST_POPB;
        else                             state_next = ST_POPA;
      end
      ST_POPB:  state_next = ST_POPA;
      ST_POPA:  state_next = ST_EXEC;
      ST_EXEC:  state_next = ST_PUSH;
      ST_PUSH:  state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign pop_req   = (state_reg == ST_POPB) || (state_reg == ST_POPA);
  assign push_req  = (state_reg == ST_PUSH);
  assign push_data = push_req ? result : '0;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      opcode_reg  <= '0;
      use_imm_reg <= 1'b0;
      imm_reg     <= '0;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      result      <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            opcode_reg  <= opcode;
            use_imm_reg <= use_imm;
            imm_reg     <= imm;
            err         <= 1'b0;
          end
        end
        ST_CHECK: if (chk_fail) err <= 1'b1;
        ST_POPB:  op_b_reg <= tos;
        ST_POPA: begin
          op_a_reg <= tos;
          if (imm_binary) op_b_reg <= imm_reg;
        end
        ST_EXEC: begin
          result <= alu_value;
          zero   <= (alu_value == '0);
          carry  <= alu_carry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_alu_exec.sv
// Directed bench for stack_alu_exec with a small behavioural operand stack attached.
module tb_stack_alu_exec;
  import stack_pkg::*;

  localparam int W     = 32;
  localparam int D     = 16;
  localparam int CW    = $clog2(D) + 1;
  localparam int LIMIT = 20;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    opcode = '0;
  logic          use_imm = 1'b0;
  logic [W-1:0]  imm = '0;
  logic [W-1:0]  tos;
  logic [CW-1:0] stack_count;
  logic          pop_req, push_req, busy, done, zero, carry, err;
  logic [W-1:0]  push_data, result;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural stack: loaded by the stimulus, popped/pushed by the DUT.
  logic [W-1:0] mem [0:D-1];
  int           cnt = 0;
  int           pop_total = 0;
  int           push_total = 0;
  logic         ld_en = 1'b0;
  int           ld_n = 0;
  logic [W-1:0] ld0 = '0;
  logic [W-1:0] ld1 = '0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ld_en) begin
      cnt    <= ld_n;
      mem[0] <= ld0;
      mem[1] <= ld1;
    end else begin
      if (pop_req && cnt > 0) cnt <= cnt - 1;
      if (push_req) begin
        mem[cnt] <= push_data;
        cnt      <= cnt + 1;
      end
    end
    if (pop_req)  pop_total  <= pop_total + 1;
    if (push_req) push_total <= push_total + 1;
  end

  assign tos         = (cnt > 0) ? mem[cnt-1] : '0;
  assign stack_count = CW'(cnt);

  stack_alu_exec #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .start       (start),
    .opcode      (opcode),
    .use_imm     (use_imm),
    .imm         (imm),
    .tos         (tos),
    .stack_count (stack_count),
    .pop_req     (pop_req),
    .push_req    (push_req),
    .push_data   (push_data),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .carry       (carry),
    .err         (err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
    ld_en = 1'b1;
    ld_n  = n;
    ld0   = a;
    ld1   = b;
    step();
    ld_en = 1'b0;
  endtask

  // Returns in cycle 1 (start sampled at edge 0).
  task automatic start_op(input logic [3:0] op, input logic ui, input logic [W-1:0] im);
    opcode  = op;
    use_imm = ui;
    imm     = im;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Reports the cycle in which done is seen, then steps back into IDLE.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < LIMIT) begin
      step();
      n++;
    end
    step();
  endtask

  int pc0, pu0, n;

  initial begin
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pop", 64'(pop_req), 64'd0);
    check("rst_push", 64'(push_req), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", {61'd0, zero, carry, err}, 64'd0);
    step();
    RESET = 1'b0;
    step();

    // ADD on [3,4]: full cycle-by-cycle sequence
    load(2, 32'd3, 32'd4);
    pc0 = pop_total; pu0 = push_total;
    start_op(OP_ADD, 1'b0, '0);
    check("add_c1_busy", 64'(busy), 64'd1);
    check("add_c1_pop", 64'(pop_req), 64'd0);
    step();
    check("add_c2_pop", 64'(pop_req), 64'd1);
    step();
    check("add_c3_pop", 64'(pop_req), 64'd1);
    step();
    check("add_c4_strobes", {62'd0, pop_req, push_req}, 64'd0);
    step();
    check("add_c5_push", 64'(push_req), 64'd1);
    check("add_c5_data", 64'(push_data), 64'd7);
    check("add_c5_done", 64'(done), 64'd0);
    step();
    check("add_c6_done", 64'(done), 64'd1);
    step();
    check("add_idle", {62'd0, busy, done}, 64'd0);
    check("add_result", 64'(result), 64'd7);
    check("add_flags", {61'd0, zero, carry, err}, 64'd0);
    check("add_count", 64'(stack_count), 64'd1);
    check("add_tos", 64'(tos), 64'd7);
    check("add_pops", 64'(pop_total - pc0), 64'd2);
    check("add_pushes", 64'(push_total - pu0), 64'd1);

    // ADD immediate with wrap-around
    load(1, 32'hFFFF_FFFF, '0);
    pc0 = pop_total; pu0 = push_total;
    start_op(OP_ADD, 1'b1, 32'd1);
    wait_done(1, n);
    check("addi_latency", 64'(n), 64'd5);
    check("addi_result", 64'(result), 64'd0);
    check("addi_zero_carry", {62'd0, zero, carry}, 64'd3);
    check("addi_pops", 64'(pop_total - pc0), 64'd1);
    check("addi_pushes", 64'(push_total - pu0), 64'd1);
    check("addi_stack", {32'(stack_count), tos}, {32'd1, 32'd0});

    // SUB underflow
    load(1, 32'd5, '0);
    pc0 = pop_total; pu0 = push_total;
    start_op(OP_SUB, 1'b0, '0);
    wait_done(1, n);
    check("uflow_latency", 64'(n), 64'd2);
    check("uflow_err", 64'(err), 64'd1);
    check("uflow_strobes", 64'((pop_total - pc0) + (push_total - pu0)), 64'd0);
    check("uflow_stack", {32'(stack_count), tos}, {32'd1, 32'd5});
    check("uflow_held", {30'd0, zero, carry, result}, {30'd0, 2'b11, 32'd0});

    // Illegal opcode, then SLT clears err
    load(2, 32'd2, 32'd5);
    pc0 = pop_total; pu0 = push_total;
    start_op(4'd12, 1'b0, '0);
    wait_done(1, n);
    check("illegal_latency", 64'(n), 64'd2);
    check("illegal_err", 64'(err), 64'd1);
    check("illegal_strobes", 64'((pop_total - pc0) + (push_total - pu0)), 64'd0);
    load(2, 32'hFFFF_FFFD, 32'd5);
    start_op(OP_SLT, 1'b0, '0);
    check("slt_err_cleared", 64'(err), 64'd0);
    wait_done(1, n);
    check("slt_latency", 64'(n), 64'd6);
    check("slt_result", 64'(result), 64'd1);
    check("slt_flags", {61'd0, zero, carry, err}, 64'd0);
    check("slt_stack", {32'(stack_count), tos}, {32'd1, 32'd1});

    // NOT with a start pulse while busy
    load(1, 32'h0000_000F, '0);
    pu0 = push_total;
    start_op(OP_NOT, 1'b1, 32'd99);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(3, n);
    check("not_latency", 64'(n), 64'd5);
    check("not_result", 64'(result), 64'hFFFF_FFF0);
    step(); step(); step();
    check("not_no_requeue", 64'(busy), 64'd0);
    check("not_pushes", 64'(push_total - pu0), 64'd1);
    check("not_stack", {32'(stack_count), tos}, {32'd1, 32'hFFFF_FFF0});

    // Reset while in POPA
    load(2, 32'd10, 32'd20);
    pc0 = pop_total; pu0 = push_total;
    start_op(OP_ADD, 1'b0, '0);
    step();
    step();
    check("rst_mid_in_popa", 64'(pop_req), 64'd1);
    RESET = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_pop", 64'(pop_req), 64'd0);
    check("rst_mid_result", 64'(result), 64'd0);
    step(); step();
    RESET = 1'b0;
    step(); step();
    check("rst_mid_pushes", 64'(push_total - pu0), 64'd0);
    check("rst_mid_pops", 64'(pop_total - pc0), 64'd1);
    load(2, 32'd1, 32'd2);
    start_op(OP_ADD, 1'b0, '0);
    wait_done(1, n);
    check("post_rst_latency", 64'(n), 64'd6);
    check("post_rst_result", 64'(result), 64'd3);

    // SUB borrow and shift with immediate
    load(2, 32'd1, 32'd2);
    start_op(OP_SUB, 1'b0, '0);
    wait_done(1, n);
    check("sub_result", 64'(result), 64'hFFFF_FFFF);
    check("sub_borrow", {62'd0, zero, carry}, 64'd1);
    load(1, 32'h8000_0000, '0);
    start_op(OP_SHR, 1'b1, 32'd31);
    wait_done(1, n);
    check("shr_result", 64'(result), 64'd1);
    check("shr_carry", 64'(carry), 64'd0);
    load(1, 32'd6, '0);
    start_op(OP_NEG, 1'b0, '0);
    wait_done(1, n);
    check("neg_result", 64'(result), 64'hFFFF_FFFA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
